// File: rtl/fifo_pkg.sv
// Shared constants and types for the 1024x16 synchronous FIFO and its storage RAM.
package fifo_pkg;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1024;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/sdp_ram_1024x16.sv
// Simple dual-port RAM, one write port and one read port with registered read data.
module sdp_ram_1024x16
    import fifo_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  ptr_t  waddr,
    input  word_t wdata,
    input  logic  re,
    input  ptr_t  raddr,
    output word_t rdata
);
    word_t mem [DEPTH];
    word_t rdata_q;

    // NOTE: neither the array nor its read register is reset, so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/sync_fifo_1024x16.sv
// Single-clock 1024x16 FIFO, standard read mode, registered flags and occupancy count.
// Define FIFO_ERR_FLAGS_EN to add registered overflow/underflow pulse outputs.
module sync_fifo_1024x16
    import fifo_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  data_count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);
    ptr_t  wr_ptr_q, wr_ptr_d;
    ptr_t  rd_ptr_q, rd_ptr_d;
    cnt_t  count_q,  count_d;
    logic  full_q,   full_d;
    logic  empty_q,  empty_d;
    logic  rd_vld_q, rd_vld_d;
    word_t dout_q,   dout_d;
    word_t ram_rdata;
    logic  wr_acc, rd_acc;

    sdp_ram_1024x16 u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // NOTE: every signal gets its value on every path through this block, so no latch is inferred.
    always_comb begin
        wr_acc   = wr_en & ~full_q;
        rd_acc   = rd_en & ~empty_q;
        wr_ptr_d = wr_ptr_q + ptr_t'(wr_acc);
        rd_ptr_d = rd_ptr_q + ptr_t'(rd_acc);
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
        full_d   = (count_d == cnt_t'(DEPTH));
        empty_d  = (count_d == '0);
        rd_vld_d = rd_acc;
        // The RAM register holds the fresh word only in the cycle after a read; keep a copy.
        dout_d   = rd_vld_q ? ram_rdata : dout_q;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            rd_vld_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            rd_vld_q <= rd_vld_d;
            dout_q   <= dout_d;
        end
    end

    // Stale RAM output is masked after reset until the first accepted read.
    assign dout       = rd_vld_q ? ram_rdata : dout_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign data_count = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = wr_en & full_q;
        underflow_d = rd_en & empty_q;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif
endmodule

// File: tb/tb_sync_fifo_1024x16.sv
// Self-checking bench for sync_fifo_1024x16: directed table, corner sequences, random scoreboard.
module tb_sync_fifo_1024x16;
    import fifo_pkg::*;

    logic              clk = 1'b0;
    logic              srst = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  data_count;
`ifdef FIFO_ERR_FLAGS_EN
    logic              overflow;
    logic              underflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of words plus the last word read out.
    logic [15:0] model_q[$];
    logic [15:0] model_dout = 16'h0;
    logic        model_ovf  = 1'b0;
    logic        model_udf  = 1'b0;

    sync_fifo_1024x16 dut (
        .clk        (clk),
        .srst       (srst),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .data_count (data_count)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare DUT against it after the edge.
    task automatic step(input logic w, input logic r, input logic [15:0] d, input logic rst);
        int  occ;
        bit  wa, ra;
        srst  = rst;
        wr_en = w;
        rd_en = r;
        din   = d;
        occ   = model_q.size();
        wa    = w && (occ < DEPTH);
        ra    = r && (occ > 0);
        if (rst) begin
            model_q.delete();
            model_dout = 16'h0;
            model_ovf  = 1'b0;
            model_udf  = 1'b0;
        end else begin
            model_ovf = w && (occ == DEPTH);
            model_udf = r && (occ == 0);
            if (ra) model_dout = model_q.pop_front();
            if (wa) model_q.push_back(d);
        end
        @(posedge clk);
        #1;
        check("dout",       int'(dout),       int'(model_dout));
        check("data_count", int'(data_count), model_q.size());
        check("empty",      int'(empty),      int'(model_q.size() == 0));
        check("full",       int'(full),       int'(model_q.size() == DEPTH));
`ifdef FIFO_ERR_FLAGS_EN
        check("overflow",   int'(overflow),   int'(model_ovf));
        check("underflow",  int'(underflow),  int'(model_udf));
`endif
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] din;
        logic [15:0] exp_dout;
        int          exp_count;
        logic        exp_empty;
        logic        exp_full;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int written;
        int cyc;

        vecs[0] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 2, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 3, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 2, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'h0002, 1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 16'h0000, 16'h0003, 0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h0000, 16'h0003, 0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 16'h0003, 0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 16'h00AA, 16'h0003, 1, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 16'h0000, 16'h00AA, 0, 1'b1, 1'b0};

        // Reset and idle.
        step(1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        check("rst_empty", int'(empty), 1);
        check("rst_full",  int'(full),  0);
        check("rst_count", int'(data_count), 0);
        check("rst_dout",  int'(dout),  0);
        step(1'b0, 1'b1, 16'h0, 1'b0);
        check("idle_rd_dout",  int'(dout), 0);
        check("idle_rd_count", int'(data_count), 0);
        step(1'b0, 1'b0, 16'h0, 1'b0);

        // Basic order and empty corner cases from the table.
        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].din, 1'b0);
            check($sformatf("vec%0d_dout", i),  int'(dout),       int'(vecs[i].exp_dout));
            check($sformatf("vec%0d_count", i), int'(data_count), vecs[i].exp_count);
            check($sformatf("vec%0d_empty", i), int'(empty),      int'(vecs[i].exp_empty));
            check($sformatf("vec%0d_full", i),  int'(full),       int'(vecs[i].exp_full));
        end

        // Fill, overflow attempt, drain.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 16'(i), 1'b0);
        check("fill_full",  int'(full), 1);
        check("fill_count", int'(data_count), 1024);
        step(1'b1, 1'b0, 16'hBEEF, 1'b0);
        check("ovf_count", int'(data_count), 1024);
`ifdef FIFO_ERR_FLAGS_EN
        check("ovf_pulse", int'(overflow), 1);
`endif
        step(1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 16'h0, 1'b0);
            check("drain_word", int'(dout), i);
        end
        check("drain_empty", int'(empty), 1);

        // Simultaneous read/write at count 5.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0500 + 16'(i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 16'h0600 + 16'(i), 1'b0);
            check("rw5_count", int'(data_count), 5);
            check("rw5_dout",  int'(dout), 16'h0500 + i);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0, 1'b0);

        // Simultaneous read/write at full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 16'h8000 + 16'(i), 1'b0);
        step(1'b1, 1'b1, 16'hBEEF, 1'b0);
        check("rwfull_count", int'(data_count), 1023);
        check("rwfull_dout",  int'(dout), 16'h8000);
        step(1'b0, 1'b0, 16'h0, 1'b1);

        // Wrap-around with random traffic.
        written = 0;
        cyc     = 0;
        while (written < 3000 && cyc < 20000) begin
            logic w, r;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (w && model_q.size() < DEPTH) begin
                step(w, r, 16'(written), 1'b0);
                written++;
            end else begin
                step(w, r, 16'(written), 1'b0);
            end
            cyc++;
        end
        check("wrap_budget", int'(written >= 3000), 1);
        cyc = 0;
        while (model_q.size() > 0 && cyc < 2000) begin
            step(1'b0, 1'b1, 16'h0, 1'b0);
            cyc++;
        end
        check("wrap_drained", int'(empty), 1);

        // Reset mid-operation.
        for (int i = 0; i < 600; i++) step(1'b1, 1'b0, 16'h4000 + 16'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0, 1'b0);
        step(1'b0, 1'b1, 16'h0, 1'b1);
        check("mid_rst_empty", int'(empty), 1);
        check("mid_rst_count", int'(data_count), 0);
        check("mid_rst_dout",  int'(dout), 0);
        step(1'b1, 1'b0, 16'h1234, 1'b0);
        step(1'b0, 1'b1, 16'h0, 1'b0);
        check("post_rst_dout", int'(dout), 16'h1234);
        step(1'b0, 1'b1, 16'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_1024x16.md
Name: sync_fifo_1024x16

Overview:
- Single-clock, synchronous FIFO: 1024 words x 16 bits, standard (non-FWFT) read mode.
- Registered read data, full/empty flags and an occupancy count.
- Sits between a producer FSM (push) and a consumer FSM (pop). The consumer starts draining when the count exceeds a threshold and stops on empty.
- The FIFO head feeds the address of a small lookup ROM downstream.

Parameters:
- DATA_W, 16: word width.
- DEPTH, 1024: capacity in words; must be a power of two.
- CNT_W, 11 (clog2(DEPTH)+1): width of data_count; must represent 0..DEPTH.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- srst  in  1  reset, synchronous, active-high.
- din  in  DATA_W  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- dout  out  DATA_W  registered read data.
- full  out  1  asserted when occupancy == DEPTH.
- empty  out  1  asserted when occupancy == 0.
- data_count  out  CNT_W  current occupancy, 0..1024.
- overflow  out  1  present only with FIFO_ERR_FLAGS_EN.
- underflow  out  1  present only with FIFO_ERR_FLAGS_EN.

Behaviour:
- Reset (srst=1 at a clock edge):
  - write/read pointers = 0, data_count = 0, empty = 1, full = 0, dout = 0.
  - Storage contents are not cleared.
  - srst has priority over wr_en/rd_en in the same cycle.
- Accepted write = wr_en & ~full: din is stored at wptr; wptr increments modulo DEPTH (10-bit natural wrap).
- Accepted read = rd_en & ~empty: mem[rptr] is registered into dout; rptr increments modulo DEPTH.
  - Latency: dout shows the word on the clock edge after the edge that accepts rd_en.
  - dout holds its value when no read is accepted.
- Rejected requests:
  - A write while full is ignored; memory, count and flags are unchanged.
  - A read while empty is ignored; dout is unchanged.
- data_count update per edge:
  - +1 on write only; -1 on read only.
  - Unchanged on both or neither.
- full and empty are registered and derived from the next count, so they are valid in the same cycle as data_count.
- Simultaneous wr_en and rd_en:
  - 0 < count < DEPTH: both accepted, count unchanged.
  - Empty: only the write is accepted; count becomes 1 and empty drops next cycle. There is no read-through: the word is readable from the following cycle.
  - Full: only the read is accepted; count becomes 1023 and full drops next cycle.
- Write-to-read latency: after the first write to an empty FIFO, empty deasserts on the next edge. A read issued in that cycle returns the word one edge later.
- Data order is strict FIFO across pointer wrap-around; no word is lost or duplicated.
- Reset mid-operation: the state returns to empty on the next edge. Stale storage is never presented, because pointers restart at 0 and empty gates reads.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow is a registered 1-cycle pulse on the edge after wr_en while full.
  - underflow is a registered 1-cycle pulse on the edge after rd_en while empty.
  - Both outputs are 0 in reset.
- Undefined: the ports do not exist and no logic is generated. Core behaviour is identical either way.

Decomposition:
- Shared package fifo_pkg:
  - constants DATA_W=16, DEPTH=1024, CNT_W=11, PTR_W=10.
  - typedefs word_t (logic [DATA_W-1:0]), ptr_t, cnt_t.
- Sub-module sdp_ram_1024x16:
  - simple dual-port RAM, one write port (we, waddr, wdata), one read port (re, raddr, registered rdata).
  - infers block RAM.
- The FIFO top holds pointers, count, flags and the dout register/reset.

Test Plan:
- Reset and idle: assert srst 2 cycles. Expect empty=1, full=0, data_count=0, dout=0. A rd_en pulse leaves dout=0 and data_count=0.
- Basic order: write 0x0001, 0x0002, 0x0003 on consecutive cycles, then rd_en for 3 cycles.
  - data_count goes 1,2,3 then 2,1,0.
  - dout = 0x0001, 0x0002, 0x0003, each one cycle after its rd_en.
  - empty reasserts after the third read.
- Fill and overflow: write 0x0000..0x03FF. Expect full=1 and data_count=1024.
  - An extra write of 0xBEEF is ignored; overflow pulses if enabled.
  - Draining yields 0x0000..0x03FF with no 0xBEEF.
- Simultaneous read/write:
  - At count=5, wr_en=rd_en=1 for 4 cycles: count stays 5 and order is preserved.
  - At empty, both asserted: count=1 and dout unchanged.
  - At full, both asserted: count=1023.
- Wrap-around: run 3000 words of an incrementing pattern with random wr_en/rd_en (about 50%). A scoreboard must match every dout, and count must never exceed 1024 or go below 0.
- Reset mid-operation: at count=600 with reads in progress, pulse srst for 1 cycle.
  - Next cycle: empty=1, data_count=0, dout=0.
  - Then write 0x1234 and read it back: dout=0x1234.
